// File: rtl/cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mc
// Brief    : Multi-cycle CPU core, 16-bit instructions, req/ack imem and dmem.
// Revision : 1.0
// ============================================================================
module cpu_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              hlt
);

    localparam int         c_RIDX_W = $clog2(NREG);
    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_LDI  = 4'h4;
    localparam logic [3:0] c_OP_LD   = 4'h5;
    localparam logic [3:0] c_OP_ST   = 4'h6;
    localparam logic [3:0] c_OP_BEQZ = 4'h7;
    localparam logic [3:0] c_OP_JMP  = 4'h8;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    logic [3:0]          w_op;
    logic [c_RIDX_W-1:0] w_rd, w_rs, w_rt;
    logic [DATA_W-1:0]   w_rd_val, w_rs_val, w_rt_val, w_imm_data;
    logic [PC_W-1:0]     w_imm_pc, w_pc_inc;
    logic                w_unused;

    // Register selects use only the low index bits; the rest of each field is don't-care.
    assign w_op       = ir_q[15:12];
    assign w_rd       = ir_q[8 +: c_RIDX_W];
    assign w_rs       = ir_q[4 +: c_RIDX_W];
    assign w_rt       = ir_q[0 +: c_RIDX_W];
    assign w_rd_val   = regs_q[w_rd];
    assign w_rs_val   = regs_q[w_rs];
    assign w_rt_val   = regs_q[w_rt];
    assign w_imm_data = DATA_W'(ir_q[7:0]);
    assign w_imm_pc   = PC_W'(ir_q[7:0]);
    assign w_pc_inc   = pc_q + PC_W'(1);
    assign w_unused   = ^ir_q[11:8];

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign hlt       = (state_q == S_HALT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Reset forces FETCH asynchronously, so the request is masked while rst is high.
                imem_req = ~rst;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                retire  = 1'b1;
                pc_d    = w_pc_inc;
                case (w_op)
                    c_OP_ADD:  regs_d[w_rd] = w_rs_val + w_rt_val;
                    c_OP_SUB:  regs_d[w_rd] = w_rs_val - w_rt_val;
                    c_OP_AND:  regs_d[w_rd] = w_rs_val & w_rt_val;
                    c_OP_OR:   regs_d[w_rd] = w_rs_val | w_rt_val;
                    c_OP_LDI:  regs_d[w_rd] = w_imm_data;
                    c_OP_LD, c_OP_ST: begin
                        state_d = S_MEM;
                        retire  = 1'b0;
                        pc_d    = pc_q;
                    end
                    c_OP_BEQZ: begin
                        if (w_rd_val == '0) begin
                            pc_d = w_imm_pc;
                        end
                    end
                    c_OP_JMP:  pc_d = w_imm_pc;
                    c_OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Operands come from ir/regs, neither of which changes until the ack.
                dmem_req   = 1'b1;
                dmem_we    = (w_op == c_OP_ST);
                dmem_addr  = w_rs_val;
                dmem_wdata = w_rd_val;
                if (dmem_ack) begin
                    if (w_op == c_OP_LD) begin
                        regs_d[w_rd] = dmem_rdata;
                    end
                    pc_d    = w_pc_inc;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_mc.md
# cpu_mc

Parametrised multi-cycle successor to the fixed 8-bit pipelined CPU top. It has configurable data width, PC width and register count, and a 16-bit instruction word. Instruction and data memories are external, each behind a req/ack handshake, so wait-state memories can be attached. It adds conditional branch, explicit halt and a per-instruction retire pulse, and it is the core the out-of-order work will wrap.

## Interface
- DATA_W, 8, register/ALU/data-address width (4..32)
- PC_W, 8, program counter and instruction address width (4..16)
- NREG, 4, number of registers (power of two, 2..16)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: one clock, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; load data valid
- dmem_rdata  in  DATA_W  load data
- pc  out  PC_W  current program counter
- retire  out  1  one-cycle pulse per completed instruction
- hlt  out  1  core halted

## Operation
- Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm=[7:0].
- Register indices use the low log2(NREG) bits. imm is zero-extended or truncated to the destination width.
- Opcodes:
  - 0 ADD: rd=rs+rt
  - 1 SUB: rd=rs−rt
  - 2 AND
  - 3 OR
  - 4 LDI: rd=imm
  - 5 LD: rd=mem[rs]
  - 6 ST: mem[rs]=rd
  - 7 BEQZ: if rd==0 then pc=imm, else pc+1
  - 8 JMP: pc=imm
  - F HALT
  - 9–E: NOP
- Arithmetic is modulo 2^DATA_W. No flags and no carry out.
- Non-branch instructions set pc=pc+1, modulo 2^PC_W (wraps to 0).
- FSM states FETCH, EXEC, MEM, HALT:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata into the instruction register and go to EXEC.
  - EXEC, ALU/LDI/NOP/branch: write rd and update pc at the end of the cycle, pulse retire, go to FETCH.
  - EXEC, LD/ST: go to MEM, pc unchanged.
  - EXEC, HALT: go to HALT and pulse retire; pc is not incremented.
  - MEM: dmem_req=1, dmem_we=(op==ST), dmem_addr=rs, dmem_wdata=rd. All are held stable until dmem_ack.
  - MEM on ack: LD writes dmem_rdata to rd; pc+1; pulse retire; go to FETCH.
  - HALT: hlt=1, no requests. Only rst exits.
- Acks are ignored when the matching req is low.
- Reset values:
  - state=FETCH, pc=0, all registers=0, instruction register=0.
  - imem_req=1 from the first cycle after reset deassertion; held 0 while rst is high.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, retire=0, hlt=0.
- Reset mid-handshake: the request drops asynchronously and the in-flight access is abandoned. There is no register write or pc change.

## Timing
- imem_req and dmem_req are decoded from state (Moore). An ack in the same cycle the req first rises is valid.
- Minimum latency is 2 cycles for ALU/LDI/branch/NOP (FETCH+EXEC), 3 cycles for LD/ST.
- Each imem/dmem wait cycle adds 1 cycle.
- A register written in EXEC/MEM is visible to the next instruction's EXEC; no hazards exist.
- retire is high in exactly the final cycle of each instruction. It is never high twice in a row.
- hlt rises the cycle after HALT's EXEC and stays high.
- pc output is registered; it updates the cycle after the retire pulse.

## Test plan
- Reset then zero-wait program LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT -> r3=2, 4 retire pulses, hlt high on cycle 8, pc=3.
- DATA_W=8, ADD 200+100 -> 44. With PC_W=4, a NOP at pc=15 -> pc wraps to 0.
- ST r1→mem[r2] then LD r3←mem[r2], dmem_ack delayed 3 cycles -> dmem_addr, dmem_we and dmem_wdata stable for all 4 req cycles; r3=r1; each access takes 6 cycles.
- BEQZ with rd=0, imm=0x20 -> pc=0x20. BEQZ with rd=1 at pc=7 -> pc=8. imem_ack withheld 5 cycles -> no state change.
- Spurious imem_ack/dmem_ack in HALT and during EXEC -> ignored; hlt stays 1.
- Assert rst mid-MEM of a LD -> dmem_req=0 immediately, registers=0, pc=0; after release, fetch restarts at address 0.
